pktmux: RTL and testbench

- Packet-level N-to-1 AXI-stream multiplexer for the switch fabric. Shares one outgoing packet stream among NIN source ports.
- A round-robin grant is taken at packet boundaries and held until the granted source completes (LAST) or aborts the packet.
- Output is registered. Sits between per-port RX/crossbar buffers and a shared egress path.

---
 rtl/pktmux_pkg.sv | 9 +
 rtl/pktmux_rrsel.sv | 22 ++
 rtl/pktmux.sv | 141 ++++++++++++++
 tb/tb_pktmux.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pktmux_pkg.sv
// Shared type definitions for the pktmux packet multiplexer.
package pktmux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/pktmux_rrsel.sv
// Combinational round-robin picker: one-hot grant of the first requester
// strictly after the last owner, in circular index order.
module pktmux_rrsel #(
  parameter int NIN = 4
) (
  input  logic [NIN-1:0] i_req,
  input  logic [NIN-1:0] i_last,
  output logic [NIN-1:0] o_pick
);

  logic [2*NIN-1:0] w_dreq;
  logic [2*NIN-1:0] w_base;
  logic [2*NIN-1:0] w_dgnt;

  // Subtracting the one-hot start position from the doubled request vector
  // clears the first request at or above it; masking isolates that bit.
  assign w_dreq = {i_req, i_req};
  assign w_base = {{(NIN-1){1'b0}}, i_last, 1'b0};
  assign w_dgnt = w_dreq & ~(w_dreq - w_base);
  assign o_pick = w_dgnt[NIN-1:0] | w_dgnt[2*NIN-1:NIN];

endmodule

// File: rtl/pktmux.sv
// Packet-level N-to-1 stream multiplexer with round-robin grant held per packet
// and a registered output stage.
module pktmux
  import pktmux_pkg::*;
#(
  parameter int NIN = 4,
  parameter int DW  = 64,
  parameter int BW  = $clog2(DW/8) + 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NIN-1:0]    S_AXN_VALID,
  output logic [NIN-1:0]    S_AXN_READY,
  input  logic [NIN*DW-1:0] S_AXN_DATA,
  input  logic [NIN*BW-1:0] S_AXN_BYTES,
  input  logic [NIN-1:0]    S_AXN_LAST,
  input  logic [NIN-1:0]    S_AXN_ABORT,
  output logic              M_AXN_VALID,
  input  logic              M_AXN_READY,
  output logic [DW-1:0]     M_AXN_DATA,
  output logic [BW-1:0]     M_AXN_BYTES,
  output logic              M_AXN_LAST,
  output logic              M_AXN_ABORT,
  output logic [NIN-1:0]    o_grant
);

  state_t          r_state, w_state_nxt;
  logic [NIN-1:0]  r_grant, w_grant_nxt;
  logic [NIN-1:0]  r_ptr, w_ptr_nxt;
  logic            r_started, w_started_nxt;
  logic            r_mvalid, r_mlast, r_mabort;
  logic [DW-1:0]   r_mdata;
  logic [BW-1:0]   r_mbytes;

  logic [NIN-1:0]  w_cand, w_pick;
  logic [DW-1:0]   w_sel_data;
  logic [BW-1:0]   w_sel_bytes;
  logic            w_sel_last, w_own_abort, w_out_free, w_accept;

  assign w_cand = S_AXN_VALID & ~S_AXN_ABORT;

  pktmux_rrsel #(.NIN(NIN)) u_rrsel (
    .i_req  (w_cand),
    .i_last (r_ptr),
    .o_pick (w_pick)
  );

  always_comb begin
    w_sel_data  = '0;
    w_sel_bytes = '0;
    w_sel_last  = 1'b0;
    for (int k = 0; k < NIN; k++) begin
      w_sel_data  = w_sel_data  | (S_AXN_DATA[k*DW +: DW]  & {DW{r_grant[k]}});
      w_sel_bytes = w_sel_bytes | (S_AXN_BYTES[k*BW +: BW] & {BW{r_grant[k]}});
      w_sel_last  = w_sel_last  | (S_AXN_LAST[k] & r_grant[k]);
    end
  end

  // Owner abort masks its READY so a coincident beat is never accepted.
  assign w_own_abort = (r_state == BUSY) && |(S_AXN_ABORT & r_grant);
  assign w_out_free  = !r_mvalid || M_AXN_READY;
  assign S_AXN_READY = (r_state == BUSY && w_out_free) ? (r_grant & ~S_AXN_ABORT) : '0;
  assign w_accept    = |(S_AXN_READY & S_AXN_VALID);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_ptr_nxt     = r_ptr;
    w_started_nxt = r_started;
    case (r_state)
      IDLE: begin
        if (|w_cand) begin
          w_state_nxt   = BUSY;
          w_grant_nxt   = w_pick;
          w_ptr_nxt     = w_pick;
          w_started_nxt = 1'b0;
        end
      end
      BUSY: begin
        if (w_own_abort || (w_accept && w_sel_last)) begin
          w_state_nxt   = IDLE;
          w_grant_nxt   = '0;
          w_started_nxt = 1'b0;
        end else if (w_accept) begin
          w_started_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_ptr     <= {1'b1, {(NIN-1){1'b0}}};
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_ptr     <= w_ptr_nxt;
      r_started <= w_started_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mvalid <= 1'b0;
      r_mdata  <= '0;
      r_mbytes <= '0;
      r_mlast  <= 1'b0;
      r_mabort <= 1'b0;
    end else begin
      r_mabort <= w_own_abort && r_started;
      if (w_own_abort) begin
        r_mvalid <= 1'b0;
      end else if (w_accept) begin
        r_mvalid <= 1'b1;
        r_mdata  <= w_sel_data;
        r_mbytes <= w_sel_bytes;
        r_mlast  <= w_sel_last;
      end else if (M_AXN_READY) begin
        r_mvalid <= 1'b0;
      end
    end
  end

  assign M_AXN_VALID = r_mvalid;
  assign M_AXN_DATA  = r_mdata;
  assign M_AXN_BYTES = r_mbytes;
  assign M_AXN_LAST  = r_mlast;
  assign M_AXN_ABORT = r_mabort;
  assign o_grant     = r_grant;

endmodule

// File: tb/tb_pktmux.sv
// Directed self-checking bench for pktmux (NIN=4, DW=64, BW=4).
module tb_pktmux;

  logic         i_clk = 1'b0;
  logic         i_reset_n;
  logic [3:0]   s_valid, s_ready, s_last, s_abort;
  logic [255:0] s_data;
  logic [15:0]  s_bytes;
  logic         m_valid, m_ready, m_last, m_abort;
  logic [63:0]  m_data;
  logic [3:0]   m_bytes, grant;

  int total = 0;
  int bad   = 0;

  pktmux #(.NIN(4), .DW(64)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .S_AXN_VALID (s_valid),
    .S_AXN_READY (s_ready),
    .S_AXN_DATA  (s_data),
    .S_AXN_BYTES (s_bytes),
    .S_AXN_LAST  (s_last),
    .S_AXN_ABORT (s_abort),
    .M_AXN_VALID (m_valid),
    .M_AXN_READY (m_ready),
    .M_AXN_DATA  (m_data),
    .M_AXN_BYTES (m_bytes),
    .M_AXN_LAST  (m_last),
    .M_AXN_ABORT (m_abort),
    .o_grant     (grant)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_beat(input int k, input logic [63:0] d, input logic [3:0] b, input logic l);
    s_data[k*64 +: 64] = d;
    s_bytes[k*4 +: 4]  = b;
    s_last[k]          = l;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    s_valid = '0; s_last = '0; s_abort = '0; s_data = '0; s_bytes = '0;
    m_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_reset_n = 1'b1;
    step();
  endtask

  int          cyc, got_n;
  logic [63:0] got_d[12];
  int          got_c[12];
  int          bi[4], pk[4];
  logic [3:0]  acc;

  initial begin
    // ---------------- reset state ----------------
    i_reset_n = 1'b0;
    s_valid = '0; s_last = '0; s_abort = '0; s_data = '0; s_bytes = '0;
    m_ready = 1'b1;
    step();
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_mvalid", 64'(m_valid), 64'h0);
    chk("rst_mdata", m_data, 64'h0);
    chk("rst_sready", 64'(s_ready), 64'h0);
    chk("rst_mabort", 64'(m_abort), 64'h0);
    do_reset();

    // ---------------- single packet, source 2 ----------------
    m_ready = 1'b1;
    s_valid[2] = 1'b1; set_beat(2, 64'hA0, 4'd8, 1'b0);
    step();
    chk("sp_grant", 64'(grant), 64'h4);
    chk("sp_ready", 64'(s_ready), 64'h4);
    step();
    chk("sp_b0_valid", 64'(m_valid), 64'h1);
    chk("sp_b0_data", m_data, 64'hA0);
    set_beat(2, 64'hA1, 4'd8, 1'b0);
    step();
    chk("sp_b1_data", m_data, 64'hA1);
    set_beat(2, 64'hA2, 4'd5, 1'b1);
    step();
    chk("sp_b2_data", m_data, 64'hA2);
    chk("sp_b2_last", 64'(m_last), 64'h1);
    chk("sp_b2_bytes", 64'(m_bytes), 64'h5);
    chk("sp_grant_rel", 64'(grant), 64'h0);
    s_valid[2] = 1'b0;
    step();
    chk("sp_drained", 64'(m_valid), 64'h0);

    // ---------------- round robin, 2-beat packets ----------------
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bi[k] = 0; pk[k] = 0;
      set_beat(k, 64'(k*256), 4'd8, 1'b0);
    end
    s_valid = 4'hF; m_ready = 1'b1;
    #1;
    cyc = 0; got_n = 0;
    while (got_n < 12 && cyc < 100) begin
      if (m_valid && m_ready) begin
        got_d[got_n] = m_data;
        got_c[got_n] = cyc;
        got_n++;
      end
      acc = s_ready & s_valid;
      step();
      cyc++;
      for (int k = 0; k < 4; k++) begin
        if (acc[k]) begin
          if (bi[k] == 1) begin bi[k] = 0; pk[k]++; end
          else bi[k] = 1;
          set_beat(k, 64'(k*256 + pk[k]*2 + bi[k]), 4'd8, bi[k] == 1);
        end
      end
      #1;
    end
    chk("rr_count", 64'(got_n), 64'd12);
    for (int i = 0; i < got_n; i++) begin
      chk("rr_data", got_d[i], 64'(((i/2)%4)*256 + ((i/2)/4)*2 + (i%2)));
      if (i > 0) chk("rr_gap", 64'(got_c[i] - got_c[i-1]), 64'((i%2 == 0) ? 2 : 1));
    end

    // ---------------- backpressure, source 0, 4 beats ----------------
    do_reset();
    m_ready = 1'b1;
    s_valid[0] = 1'b1; set_beat(0, 64'hB0, 4'd8, 1'b0);
    step();
    chk("bp_grant", 64'(grant), 64'h1);
    step();
    chk("bp_b0", m_data, 64'hB0);
    set_beat(0, 64'hB1, 4'd8, 1'b0);
    step();
    chk("bp_b1", m_data, 64'hB1);
    set_beat(0, 64'hB2, 4'd8, 1'b0);
    m_ready = 1'b0;
    #1;
    chk("bp_stall_ready", 64'(s_ready), 64'h0);
    step();
    chk("bp_hold_valid", 64'(m_valid), 64'h1);
    chk("bp_hold_data", m_data, 64'hB1);
    step();
    chk("bp_hold2_data", m_data, 64'hB1);
    m_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 64'(s_ready), 64'h1);
    step();
    chk("bp_b2", m_data, 64'hB2);
    set_beat(0, 64'hB3, 4'd6, 1'b1);
    step();
    chk("bp_b3", m_data, 64'hB3);
    chk("bp_b3_last", 64'(m_last), 64'h1);
    s_valid[0] = 1'b0;
    step();
    chk("bp_drained", 64'(m_valid), 64'h0);

    // ---------------- owner abort, source 1 ----------------
    do_reset();
    m_ready = 1'b0;
    s_valid[1] = 1'b1; set_beat(1, 64'hC0, 4'd8, 1'b0);
    step();
    chk("ab_grant", 64'(grant), 64'h2);
    step();
    chk("ab_b0", m_data, 64'hC0);
    m_ready = 1'b1;
    set_beat(1, 64'hC1, 4'd8, 1'b0);
    step();
    chk("ab_b1", m_data, 64'hC1);
    m_ready = 1'b0;
    set_beat(1, 64'hC2, 4'd8, 1'b1);
    s_abort[1] = 1'b1;
    s_valid[0] = 1'b1; s_valid[2] = 1'b1;
    #1;
    chk("ab_ready_masked", 64'(s_ready), 64'h0);
    step();
    chk("ab_drop_valid", 64'(m_valid), 64'h0);
    chk("ab_pulse", 64'(m_abort), 64'h1);
    chk("ab_release", 64'(grant), 64'h0);
    s_abort[1] = 1'b0; s_valid[1] = 1'b0;
    step();
    chk("ab_pulse_end", 64'(m_abort), 64'h0);
    chk("ab_next_grant", 64'(grant), 64'h4);
    // abort with no accepted beat: grant released silently
    m_ready = 1'b1;
    s_abort[2] = 1'b1;
    #1;
    chk("ab_force_ready0", 64'(s_ready), 64'h0);
    step();
    chk("ab_silent", 64'(m_abort), 64'h0);
    chk("ab_silent_rel", 64'(grant), 64'h0);
    chk("ab_silent_valid", 64'(m_valid), 64'h0);

    // ---------------- non-owner / idle abort ----------------
    do_reset();
    m_ready = 1'b1;
    s_abort[3] = 1'b1;
    step();
    chk("na_idle_abort", 64'(m_abort), 64'h0);
    chk("na_idle_grant", 64'(grant), 64'h0);
    s_abort[3] = 1'b0;
    s_valid[0] = 1'b1; set_beat(0, 64'hE0, 4'd8, 1'b0);
    step();
    chk("na_grant", 64'(grant), 64'h1);
    s_abort[3] = 1'b1; s_valid[3] = 1'b1;
    step();
    chk("na_b0", m_data, 64'hE0);
    chk("na_busy_abort", 64'(m_abort), 64'h0);
    s_abort[3] = 1'b0; s_valid[3] = 1'b0;
    set_beat(0, 64'hE1, 4'd3, 1'b1);
    step();
    chk("na_b1", m_data, 64'hE1);
    chk("na_b1_last", 64'(m_last), 64'h1);
    chk("na_b1_abort", 64'(m_abort), 64'h0);
    s_valid[0] = 1'b0;

    // ---------------- async reset mid-packet ----------------
    do_reset();
    m_ready = 1'b1;
    s_valid[0] = 1'b1; set_beat(0, 64'hF0, 4'd8, 1'b0);
    step();
    step();
    set_beat(0, 64'hF1, 4'd8, 1'b0);
    step();
    chk("ar_b1", m_data, 64'hF1);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("ar_valid", 64'(m_valid), 64'h0);
    chk("ar_data", m_data, 64'h0);
    chk("ar_grant", 64'(grant), 64'h0);
    chk("ar_ready", 64'(s_ready), 64'h0);
    for (int k = 0; k < 4; k++) set_beat(k, 64'(k), 4'd8, 1'b0);
    s_valid = 4'hF;
    @(negedge i_clk) i_reset_n = 1'b1;
    step();
    chk("ar_first_grant", 64'(grant), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
